// File: rtl/adc_avg_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_avg_filter_pkg
// Brief    : Shared widths, default window depth and FSM encodings for the
//            ADC averaging filter.
// Revision : 1.0 - initial release
// ============================================================================
package adc_avg_filter_pkg;

    localparam int C_ADC_W              = 12;
    localparam int C_DEPTH_LOG2_DEFAULT = 3;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : adc_avg_filter_pkg
`default_nettype wire

// File: rtl/adc_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : adc_ring_buffer
// Brief    : N-entry sample store with wrapping write pointer; exposes the
//            entry about to be overwritten (the oldest sample in the window).
// Revision : 1.0 - initial release
// ============================================================================
module adc_ring_buffer
    import adc_avg_filter_pkg::*;
#(
    parameter int DEPTH_LOG2 = C_DEPTH_LOG2_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_wr_en,
    input  logic [C_ADC_W-1:0] i_wr_data,
    output logic [C_ADC_W-1:0] o_oldest
);

    localparam int C_DEPTH = 1 << DEPTH_LOG2;

    logic [C_ADC_W-1:0]    r_mem [C_DEPTH];
    logic [DEPTH_LOG2-1:0] r_ptr;

    // Storage carries no reset; the FILL phase never reads stale entries.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_wr_en) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_oldest = r_mem[r_ptr];

endmodule : adc_ring_buffer
`default_nettype wire

// File: rtl/adc_avg_filter.sv
`default_nettype none
// ============================================================================
// Module   : adc_avg_filter
// Brief    : Moving-average filter over 2^DEPTH_LOG2 ADC samples with a
//            hysteretic over-level alarm.
// Revision : 1.0 - initial release
// ============================================================================
module adc_avg_filter
    import adc_avg_filter_pkg::*;
#(
    parameter int DEPTH_LOG2 = C_DEPTH_LOG2_DEFAULT
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic [C_ADC_W-1:0] iSAMPLE,
    input  logic               iSAMPLE_VALID,
    input  logic               iCLEAR,
    input  logic [C_ADC_W-1:0] iTHRESH_HI,
    input  logic [C_ADC_W-1:0] iTHRESH_LO,
    output logic [C_ADC_W-1:0] oAVG,
    output logic               oAVG_VALID,
    output logic               oALARM,
    output logic               oFILLED
);

    localparam int                    C_SUM_W = C_ADC_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] C_LAST  = '1;

    state_t                r_state;
    state_t                w_state_next;
    logic [C_SUM_W-1:0]    r_sum;
    logic [DEPTH_LOG2-1:0] r_fill_cnt;
    logic [C_ADC_W-1:0]    r_avg;
    logic                  r_avg_valid;
    logic                  r_alarm;

    logic                  w_accept;
    logic                  w_produce;
    logic [C_ADC_W-1:0]    w_oldest;
    logic [C_ADC_W-1:0]    w_sub;
    logic [C_SUM_W-1:0]    w_sum_next;
    logic [C_ADC_W-1:0]    w_avg_new;

    adc_ring_buffer #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .i_clear   (iCLEAR),
        .i_wr_en   (w_accept),
        .i_wr_data (iSAMPLE),
        .o_oldest  (w_oldest)
    );

    assign w_accept  = iSAMPLE_VALID & ~iCLEAR;
    assign w_produce = w_accept & ((r_state == ST_RUN) | (r_fill_cnt == C_LAST));
    assign w_sub     = (r_state == ST_RUN) ? w_oldest : '0;
    // The true sum always fits C_SUM_W bits, so modular add/subtract is exact.
    assign w_sum_next = r_sum + C_SUM_W'(iSAMPLE) - C_SUM_W'(w_sub);
    assign w_avg_new  = w_sum_next[C_SUM_W-1:DEPTH_LOG2];

    always_comb begin
        w_state_next = r_state;
        if (iCLEAR) begin
            w_state_next = ST_FILL;
        end else if (w_accept && (r_state == ST_FILL) && (r_fill_cnt == C_LAST)) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_sum       <= '0;
            r_fill_cnt  <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_alarm     <= 1'b0;
        end else if (iCLEAR) begin
            r_sum       <= '0;
            r_fill_cnt  <= '0;
            r_avg_valid <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_avg_valid <= w_produce;
            if (w_accept) begin
                r_sum <= w_sum_next;
                if (r_state == ST_FILL) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
            end
            if (w_produce) begin
                r_avg <= w_avg_new;
                // Set test first so an inverted threshold pair favours the alarm.
                if (w_avg_new > iTHRESH_HI) begin
                    r_alarm <= 1'b1;
                end else if (w_avg_new < iTHRESH_LO) begin
                    r_alarm <= 1'b0;
                end
            end
        end
    end

    assign oAVG       = r_avg;
    assign oAVG_VALID = r_avg_valid;
    assign oALARM     = r_alarm;
    assign oFILLED    = (r_state == ST_RUN);

endmodule : adc_avg_filter
`default_nettype wire

// File: tb/tb_adc_avg_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_avg_filter
// Brief    : Directed self-checking bench for adc_avg_filter (DEPTH_LOG2=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_avg_filter;

    logic        clk;
    logic        rst_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic        clear;
    logic [11:0] th_hi;
    logic [11:0] th_lo;
    logic [11:0] avg;
    logic        avg_valid;
    logic        alarm;
    logic        filled;

    int checks = 0;
    int errors = 0;

    adc_avg_filter #(
        .DEPTH_LOG2 (3)
    ) dut (
        .iCLK          (clk),
        .iRST_n        (rst_n),
        .iSAMPLE       (sample),
        .iSAMPLE_VALID (sample_valid),
        .iCLEAR        (clear),
        .iTHRESH_HI    (th_hi),
        .iTHRESH_LO    (th_lo),
        .oAVG          (avg),
        .oAVG_VALID    (avg_valid),
        .oALARM        (alarm),
        .oFILLED       (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one strobe; consecutive calls keep the strobe high back-to-back.
    task automatic send(input logic [11:0] s);
        @(negedge clk);
        sample       = s;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fill8(input logic [11:0] s);
        for (int i = 0; i < 8; i++) send(s);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        th_hi        = 12'd4095;
        th_lo        = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avg", avg, 0);
        chk("rst_valid", avg_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_filled", filled, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First window: no strobe until the eighth sample
        for (int i = 1; i <= 7; i++) begin
            send(12'd100);
            chk($sformatf("fill_novalid_%0d", i), avg_valid, 0);
            chk($sformatf("fill_nofilled_%0d", i), filled, 0);
        end
        send(12'd100);
        chk("fill8_valid", avg_valid, 1);
        chk("fill8_avg", avg, 100);
        chk("fill8_filled", filled, 1);

        // Window wrap: each 900 replaces a 100
        for (int k = 1; k <= 8; k++) begin
            send(12'd900);
            chk($sformatf("wrap_valid_%0d", k), avg_valid, 1);
            chk($sformatf("wrap_avg_%0d", k), avg, 100 + 100 * k);
        end
        idle();
        chk("hold_valid", avg_valid, 0);
        chk("hold_avg", avg, 900);

        // Truncation and full-scale
        for (int i = 0; i < 7; i++) send(12'd0);
        send(12'd7);
        chk("trunc_avg", avg, 0);
        fill8(12'd4095);
        chk("fullscale_avg", avg, 4095);
        chk("fullscale_alarm", alarm, 0);

        // Hysteresis
        th_hi = 12'd2000;
        th_lo = 12'd1000;
        fill8(12'd2001);
        chk("hys_2001_avg", avg, 2001);
        chk("hys_2001_alarm", alarm, 1);
        fill8(12'd1500);
        chk("hys_1500_avg", avg, 1500);
        chk("hys_1500_alarm", alarm, 1);
        fill8(12'd1000);
        chk("hys_1000_avg", avg, 1000);
        chk("hys_1000_alarm", alarm, 1);
        send(12'd999);
        chk("hys_999_first_avg", avg, 999);
        chk("hys_999_first_alarm", alarm, 0);
        for (int i = 0; i < 7; i++) send(12'd999);
        chk("hys_999_alarm", alarm, 0);
        fill8(12'd2000);
        chk("hys_2000_avg", avg, 2000);
        chk("hys_2000_alarm", alarm, 0);
        fill8(12'd2001);
        chk("reset_alarm_set", alarm, 1);
        idle();
        chk("alarm_holds_idle", alarm, 1);

        // Clear collides with a valid 4000
        @(negedge clk);
        clear        = 1'b1;
        sample       = 12'd4000;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_alarm", alarm, 0);
        chk("clr_filled", filled, 0);
        chk("clr_valid", avg_valid, 0);
        chk("clr_avg_hold", avg, 2001);
        idle();
        for (int i = 1; i <= 7; i++) begin
            send(12'd50);
            chk($sformatf("clr_fill_novalid_%0d", i), avg_valid, 0);
        end
        send(12'd50);
        chk("clr_refill_valid", avg_valid, 1);
        chk("clr_refill_avg", avg, 50);
        idle();

        // Reset mid-window, then 16 back-to-back strobes
        for (int i = 0; i < 5; i++) send(12'd300);
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("midrst_avg", avg, 0);
        chk("midrst_valid", avg_valid, 0);
        chk("midrst_alarm", alarm, 0);
        chk("midrst_filled", filled, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send(12'd200);
            chk($sformatf("b2b_valid_%0d", i), avg_valid, (i >= 8) ? 1 : 0);
            if (i >= 8) chk($sformatf("b2b_avg_%0d", i), avg, 200);
        end
        idle();
        chk("b2b_end_valid", avg_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adc_avg_filter
`default_nettype wire
